// File: rtl/start_seq_pkg.sv
// Shared types and defaults for the start sequencer.
// Watchdog support is compiled in only when START_SEQ_TIMEOUT_EN is defined.
package start_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int PEND_DEPTH_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 1024;
  localparam int WDOG_W             = 16;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus a history flop; pulse_out is high for one cycle
// after each sampled 0->1 transition of async_in.
module sync_edge_detect (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic pulse_out
);

  logic s0;
  logic v1;
  logic v2;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      s0 <= async_in;
      v1 <= s0;
      v2 <= v1;
    end
  end

  assign pulse_out = v1 & ~v2;

endmodule

// File: rtl/start_sequencer.sv
// Turns external start edges into queued one-shot datapath launches.
// Define START_SEQ_TIMEOUT_EN to add the RUN-state watchdog and timeout_err.
module start_sequencer
  import start_seq_pkg::*;
#(
  parameter  int PEND_DEPTH     = PEND_DEPTH_DEF,
  parameter  int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  localparam int CW             = $clog2(PEND_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start_data,
  input  logic          clear,
  input  logic          dp_ready,
  input  logic          dp_done,
  output logic          dp_load,
  output logic          busy,
  output logic          job_done,
  output logic [CW-1:0] pending_cnt,
  output logic          overflow,
  output logic          timeout_err,
  output state_t        state
);

  localparam logic [CW-1:0] CNT_MAX = CW'(PEND_DEPTH);

  logic start_pulse;
  logic launch;

  sync_edge_detect u_sync (
    .clk       (clk),
    .n_rst     (n_rst),
    .async_in  (start_data),
    .pulse_out (start_pulse)
  );

  // A launch consumes one queued start on the IDLE->LOAD edge.
  assign launch = (state == IDLE) && (pending_cnt != '0) && dp_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pending_cnt <= '0;
      overflow    <= 1'b0;
    end else if (clear) begin
      pending_cnt <= '0;
      overflow    <= 1'b0;
    end else if (start_pulse && !launch) begin
      if (pending_cnt == CNT_MAX) begin
        overflow <= 1'b1;
      end else begin
        pending_cnt <= pending_cnt + CW'(1);
      end
    end else if (launch && !start_pulse) begin
      pending_cnt <= pending_cnt - CW'(1);
    end
  end

`ifdef START_SEQ_TIMEOUT_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0] wdog;
  logic              wdog_expired;

  // dp_done arriving on the expiry cycle takes precedence over the timeout.
  assign wdog_expired = (state == RUN) && (wdog == WDOG_LAST) && !dp_done;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == LOAD) begin
        wdog <= '0;
      end else if (state == RUN) begin
        wdog <= wdog + WDOG_W'(1);
      end
      if (clear) begin
        timeout_err <= 1'b0;
      end else if (wdog_expired) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      dp_load  <= 1'b0;
      busy     <= 1'b0;
      job_done <= 1'b0;
    end else begin
      dp_load  <= 1'b0;
      job_done <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            state   <= LOAD;
            dp_load <= 1'b1;
            busy    <= 1'b1;
          end
        end
        LOAD: state <= RUN;
        RUN: begin
          if (dp_done) begin
            state    <= IDLE;
            busy     <= 1'b0;
            job_done <= 1'b1;
          end
`ifdef START_SEQ_TIMEOUT_EN
          else if (wdog_expired) begin
            state <= ERR;
            busy  <= 1'b0;
          end
`endif
        end
        ERR: begin
          if (clear) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_start_sequencer.sv
// Self-checking bench for start_sequencer: vector table, directed corner
// sequences and a randomized run scored against a job-level reference model.
module tb_start_sequencer;
  import start_seq_pkg::*;

  localparam int PD = 4;
  localparam int TC = 8;
  localparam int CW = $clog2(PD + 1);
  localparam int EW = 5 + CW;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start_data;
  logic          clear;
  logic          dp_ready;
  logic          dp_done;
  logic          dp_load;
  logic          busy;
  logic          job_done;
  logic [CW-1:0] pending_cnt;
  logic          overflow;
  logic          timeout_err;
  state_t        state;

  int n_cmp = 0;
  int n_bad = 0;

  // clock/reset
  always #5 clk = ~clk;

  start_sequencer #(.PEND_DEPTH(PD), .TIMEOUT_CYCLES(TC)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start_data  (start_data),
    .clear       (clear),
    .dp_ready    (dp_ready),
    .dp_done     (dp_done),
    .dp_load     (dp_load),
    .busy        (busy),
    .job_done    (job_done),
    .pending_cnt (pending_cnt),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .state       (state)
  );

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_edge();
    start_data = 1'b1;
    tick();
    tick();
    start_data = 1'b0;
    tick();
    tick();
  endtask

  // reference model: pending count, job age (-1 none, 0 load cycle, k k-th run cycle)
  int       m_pend;
  int       m_job;
  bit       m_ovf;
  bit       m_err;
  bit       m_terr;
  bit       d1, d2, d3;
  logic [EW-1:0] exp_q[$];

  task automatic model_reset();
    m_pend = 0; m_job = -1; m_ovf = 0; m_err = 0; m_terr = 0;
    d1 = 0; d2 = 0; d3 = 0;
    exp_q.delete();
  endtask

  task automatic reset_dut();
    n_rst = 1'b0;
    start_data = 1'b0; clear = 1'b0; dp_ready = 1'b0; dp_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    n_rst = 1'b1;
  endtask

  task automatic model_step();
    bit pulse, launch, done_now;
    pulse    = d2 && !d3;
    launch   = (m_job < 0) && !m_err && (m_pend > 0) && dp_ready;
    done_now = 0;
    if (clear) begin
      m_pend = 0;
      m_ovf  = 0;
    end else if (pulse && !launch) begin
      if (m_pend == PD) m_ovf = 1;
      else m_pend++;
    end else if (launch && !pulse) begin
      m_pend--;
    end
    if (launch) m_job = 0;
    else if (m_job == 0) m_job = 1;
    else if (m_job > 0) begin
      if (dp_done) begin
        m_job = -1;
        done_now = 1;
      end
`ifdef START_SEQ_TIMEOUT_EN
      else if (m_job == TC) begin
        m_job = -1;
        m_err = 1;
        m_terr = 1;
      end
`endif
      else m_job++;
    end else if (m_err && clear) begin
      m_err = 0;
    end
    if (clear) m_terr = 0;
    d3 = d2; d2 = d1; d1 = start_data;
    exp_q.push_back({m_job == 0, m_job >= 0, done_now, m_ovf, m_terr, CW'(m_pend)});
  endtask

  typedef struct {
    logic sd, rdy, done;
    logic load, bsy, jd;
    int   cnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [EW-1:0] got, e;
    int loads, dones, rdy_pct;

    // reset state
    n_rst = 1'b0;
    start_data = 1'b0; clear = 1'b0; dp_ready = 1'b0; dp_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", {dp_load, busy, job_done, overflow, timeout_err}, 0);
    check("reset_cnt", pending_cnt, 0);
    check("reset_state", state, IDLE);

    // single start with dp_ready held high
    tbl[0] = '{0, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{1, 1, 0, 0, 0, 0, 1};
    tbl[4] = '{1, 1, 0, 1, 1, 0, 0};
    tbl[5] = '{0, 1, 0, 0, 1, 0, 0};
    tbl[6] = '{0, 1, 0, 0, 1, 0, 0};
    tbl[7] = '{0, 1, 1, 0, 0, 1, 0};
    tbl[8] = '{0, 1, 0, 0, 0, 0, 0};
    n_rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      start_data = tbl[i].sd; dp_ready = tbl[i].rdy; dp_done = tbl[i].done;
      tick();
      check($sformatf("tbl%0d_load", i), dp_load, tbl[i].load);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      check($sformatf("tbl%0d_job_done", i), job_done, tbl[i].jd);
      check($sformatf("tbl%0d_cnt", i), pending_cnt, tbl[i].cnt);
    end
    dp_done = 1'b0;

    // queue fill, overflow, drain, clear
    reset_dut();
    for (int i = 0; i < 4; i++) start_edge();
    check("queue_cnt_full", pending_cnt, 4);
    check("queue_ovf_before", overflow, 0);
    start_edge();
    check("queue_cnt_sat", pending_cnt, 4);
    check("queue_ovf_set", overflow, 1);
    dp_ready = 1'b1;
    loads = 0; dones = 0;
    for (int i = 0; i < 40; i++) begin
      dp_done = busy && !dp_load;
      tick();
      if (dp_load) loads++;
      if (job_done) dones++;
    end
    dp_done = 1'b0;
    check("drain_loads", loads, 4);
    check("drain_dones", dones, 4);
    check("drain_cnt", pending_cnt, 0);
    check("drain_ovf_sticky", overflow, 1);
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    check("spurious_done", {job_done, busy}, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_ovf", overflow, 0);

    // start pulse coincides with a launch decrement
    reset_dut();
    start_edge();
    start_edge();
    check("simul_cnt_pre", pending_cnt, 2);
    start_data = 1'b1;
    tick();
    tick();
    dp_ready = 1'b1;
    tick();
    check("simul_cnt", pending_cnt, 2);
    check("simul_load", dp_load, 1);
    check("simul_ovf", overflow, 0);
    start_data = 1'b0; dp_ready = 1'b0;
    tick();
    check("simul_cnt_after", pending_cnt, 2);

    // asynchronous reset in the middle of a job
    reset_dut();
    start_edge();
    start_edge();
    dp_ready = 1'b1;
    tick();
    check("midrst_load", dp_load, 1);
    tick();
    check("midrst_run", {busy, state == RUN}, 2'b11);
    check("midrst_cnt_pre", pending_cnt, 1);
    n_rst = 1'b0;
    #1;
    check("midrst_outputs", {dp_load, busy, job_done, overflow, timeout_err}, 0);
    check("midrst_cnt", pending_cnt, 0);
    @(negedge clk);
    n_rst = 1'b1;
    loads = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dp_load) loads++;
    end
    check("midrst_no_load", loads, 0);
    check("midrst_idle", state, IDLE);

    // watchdog behaviour
    reset_dut();
    dp_ready = 1'b1;
    start_edge();
    check("wd_load", dp_load, 1);
`ifdef START_SEQ_TIMEOUT_EN
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 8) check("wd_busy_last_run", busy, 1);
    end
    check("wd_busy_err", busy, 0);
    check("wd_terr", timeout_err, 1);
    check("wd_state_err", state, ERR);
    start_edge();
    check("wd_err_queues", pending_cnt, 1);
    check("wd_err_no_load", {dp_load, state == ERR}, 2'b01);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("wd_clear_state", state, IDLE);
    check("wd_clear_terr", timeout_err, 0);
    check("wd_clear_cnt", pending_cnt, 0);
    start_edge();
    check("wd_resume_load", dp_load, 1);
    tick();
`else
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 9 || k == 20) begin
        check($sformatf("nowd_busy_%0d", k), busy, 1);
        check($sformatf("nowd_state_%0d", k), state, RUN);
        check($sformatf("nowd_terr_%0d", k), timeout_err, 0);
      end
    end
`endif
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    check("wd_late_done", {job_done, busy}, 2'b10);

    // randomized run against the reference model (scoreboard)
    reset_dut();
    for (int i = 0; i < 900; i++) begin
      rdy_pct = (i < 300) ? 2 : 7;
      if ($urandom_range(0, 9) < 3) start_data = ~start_data;
      dp_ready = ($urandom_range(0, 9) < rdy_pct);
      dp_done  = ($urandom_range(0, 9) < 2);
      clear    = ($urandom_range(0, 99) < 3);
      @(posedge clk);
      model_step();
      @(negedge clk);
      got = {dp_load, busy, job_done, overflow, timeout_err, pending_cnt};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL rand_cycle_%0d: got %b expected %b (load,busy,done,ovf,terr,cnt)", i, got, e);
      end
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/start_sequencer.md
Name: start_sequencer

Overview:
- Converts the raw external start level into queued one-shot job launches for a downstream processing datapath.
- Owns a synchroniser plus rising-edge detector, a saturating pending-start counter and a launch FSM.
- The FSM issues a one-cycle load pulse when the datapath is ready, then waits for its done pulse, with an optional watchdog.
- Sits between the top-level start input and the datapath control pins.

Parameters:
PEND_DEPTH, 4, max queued start events (>=1)
TIMEOUT_CYCLES, 1024, RUN-state watchdog limit in clk cycles (used only with the optional feature)

Ports:
clk  input  1  system clock, all flops posedge
n_rst  input  1  asynchronous active-low reset
start_data  input  1  raw start level, asynchronous to clk
clear  input  1  synchronous: flush pending, clear sticky flags, leave ERR
dp_ready  input  1  datapath can accept a job
dp_done  input  1  one-cycle pulse, job finished
dp_load  output  1  one-cycle launch pulse to datapath
busy  output  1  high in LOAD and RUN
job_done  output  1  one-cycle pulse mirroring accepted dp_done
pending_cnt  output  $clog2(PEND_DEPTH+1)  queued starts
overflow  output  1  sticky: start arrived while queue full
timeout_err  output  1  sticky: watchdog expired

Behaviour:
- Reset: the interface is one clock (clk) and an asynchronous active-low reset (n_rst). While n_rst=0, all flops clear: sync chain 0, FSM IDLE, pending_cnt 0, dp_load/busy/job_done/overflow/timeout_err 0, watchdog 0. Reset mid-job drops the job silently.
- Edge path: sync flop s0 feeds v1 then v2. Internal start_pulse = v1 & !v2.
  - start_data first sampled 1 at edge N gives start_pulse high for the cycle after edge N+1.
  - start_data held high gives one pulse only; a re-arm needs a sampled 0.
- Pending counter, updated at the edge that ends the start_pulse cycle:
  - inc only: +1, saturating at PEND_DEPTH. Inc while already full: count unchanged, overflow<=1.
  - dec only (launch): -1.
  - inc and dec together: unchanged, no overflow even when full.
  - clear: count<=0 and overflow<=0. Clear has priority over a simultaneous inc.
- FSM states (enum):
  - IDLE: if pending_cnt>0 and dp_ready -> LOAD, with the decrement taken on this transition edge.
  - LOAD: dp_load=1 for exactly one cycle -> RUN. busy=1.
  - RUN: busy=1. dp_done=1 -> IDLE, with job_done=1 registered in the next cycle. Watchdog expiry -> ERR.
  - ERR: busy=0, no launches, pending keeps counting. clear -> IDLE.
- Outputs are registered Moore except pending_cnt, which is the counter register itself.
- Launch latency: from the start_pulse cycle with an empty queue and dp_ready=1, dp_load asserts 2 cycles later.
- Spurious signals: dp_done outside RUN is ignored. clear in IDLE/LOAD/RUN does not alter FSM state.
- Back-to-back launches: minimum 3 cycles between dp_load pulses (LOAD, RUN>=1, IDLE).

Optional Feature:
- START_SEQ_TIMEOUT_EN defined: a 16-bit watchdog runs.
  - Cleared on entering RUN, increments each RUN cycle.
  - When it equals TIMEOUT_CYCLES-1 without dp_done, the FSM goes to ERR and timeout_err<=1, held until clear.
  - dp_done in the same cycle as expiry wins: the FSM goes to IDLE.
- Not defined: no watchdog flops, timeout_err tied 0, RUN waits indefinitely, ERR unreachable.

Decomposition:
- Package start_seq_pkg: state_t enum {IDLE, LOAD, RUN, ERR}, default constants for PEND_DEPTH and TIMEOUT_CYCLES, watchdog width constant WDOG_W=16.
- One sub-module, sync_edge_detect: clk, n_rst, async_in -> pulse_out, containing the 3-flop chain.
- Counter and FSM live in start_sequencer.

Test Plan:
- Reset: drive n_rst=0 mid-RUN -> all outputs 0 immediately, pending_cnt=0. After release, FSM idle with no dp_load.
- Single start, dp_ready=1: start_data 0->1 sampled at edge 5 -> start_pulse after edge 6, dp_load in the cycle after edge 8, busy high. dp_done 3 cycles later -> job_done pulse, busy 0.
- Queue: five start edges (with 0 gaps) while dp_ready=0, PEND_DEPTH=4 -> pending_cnt=4, overflow=1. dp_ready=1 -> four dp_load pulses, count 4->0. clear -> overflow 0.
- Simultaneous: start_pulse coincides with IDLE->LOAD decrement at pending_cnt=2 -> pending stays 2, no overflow.
- Timeout (macro on, TIMEOUT_CYCLES=8): no dp_done -> ERR after 8 RUN cycles, timeout_err=1, busy=0. Starts keep queuing. clear -> IDLE and launch resumes.
- Macro off: same stimulus -> stays in RUN, timeout_err=0. A late dp_done completes normally.
